// File: rtl/trap_ctrl.sv
// Commit-stage trap sequencer: arbitrates interrupt/exceptions/mret, pulses the CSR file, then flushes and redirects fetch.
// Optional feature: TRAP_CTRL_VECTORED_EN enables vectored interrupt targets (mtvec mode 2'b01).
module trap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_int_i,
  input  logic        valid_i,
  input  logic        illegal_inst_i,
  input  logic        l_access_fault_i,
  input  logic        s_access_fault_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic [31:0] pc_cur_i,
  input  logic [31:0] pc_next_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        interrupt_o,
  output logic        illegal_inst_o,
  output logic        l_access_fault_o,
  output logic        s_access_fault_o,
  output logic        ecall_m_o,
  output logic        mret_o,
  output logic [31:0] epc_cur_o,
  output logic [31:0] epc_next_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   int_pend;
  logic                   int_rise;
  logic                   int_take;
  logic                   trap;
  logic                   p_int, p_ill, p_lf, p_sf, p_ecall, p_mret;
  logic                   flush, redirect;
  logic [31:0]            redirect_pc, epc_cur, epc_next;
  logic [31:0]            trap_base;
  logic [31:0]            trap_target;
  logic                   unused_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ext_int_i};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign int_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign int_take = int_pend & mstatus_i[3] & valid_i;

  // A new edge arriving in the issue cycle must win over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_pend <= 1'b0;
    else     int_pend <= int_rise | (int_pend & ~p_int);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign trap_base = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  logic is_int_q;

  // Remembers whether the trap issued last cycle was the interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) is_int_q <= 1'b0;
    else     is_int_q <= p_int;
  end

  assign trap_target = (is_int_q && mtvec_i[1:0] == 2'b01) ? trap_base + 32'h2C : trap_base;
  assign unused_bits = ^{mstatus_i[31:4], mstatus_i[2:0]};
`else
  assign trap_target = trap_base;
  assign unused_bits = ^{mstatus_i[31:4], mstatus_i[2:0], mtvec_i[1:0]};
`endif

  always_comb begin
    state_nxt   = state;
    trap        = 1'b0;
    p_int       = 1'b0;
    p_ill       = 1'b0;
    p_lf        = 1'b0;
    p_sf        = 1'b0;
    p_ecall     = 1'b0;
    p_mret      = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    epc_cur     = '0;
    epc_next    = '0;
    unique case (state)
      IDLE: begin
        if (valid_i) begin
          if (int_take) begin
            p_int = 1'b1;
            trap  = 1'b1;
          end else if (illegal_inst_i) begin
            p_ill = 1'b1;
            trap  = 1'b1;
          end else if (l_access_fault_i) begin
            p_lf = 1'b1;
            trap = 1'b1;
          end else if (s_access_fault_i) begin
            p_sf = 1'b1;
            trap = 1'b1;
          end else if (ecall_i) begin
            p_ecall = 1'b1;
            trap    = 1'b1;
          end else if (mret_i) begin
            p_mret    = 1'b1;
            flush     = 1'b1;
            state_nxt = RET;
          end
          if (trap) begin
            flush     = 1'b1;
            epc_cur   = pc_cur_i;
            epc_next  = pc_next_i;
            state_nxt = TRAP;
          end
        end
      end
      TRAP: begin
        redirect    = 1'b1;
        redirect_pc = trap_target;
        state_nxt   = IDLE;
      end
      RET: begin
        redirect    = 1'b1;
        redirect_pc = mepc_i;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates everything so outputs drop without waiting for an edge.
  assign interrupt_o      = p_int & ~rst;
  assign illegal_inst_o   = p_ill & ~rst;
  assign l_access_fault_o = p_lf & ~rst;
  assign s_access_fault_o = p_sf & ~rst;
  assign ecall_m_o        = p_ecall & ~rst;
  assign mret_o           = p_mret & ~rst;
  assign flush_o          = flush & ~rst;
  assign redirect_o       = redirect & ~rst;
  assign redirect_pc_o    = rst ? '0 : redirect_pc;
  assign epc_cur_o        = rst ? '0 : epc_cur;
  assign epc_next_o       = rst ? '0 : epc_next;
  assign busy_o           = (state != IDLE) & ~rst;

endmodule
